// File: rtl/mem_pkg.sv
// Shared constants for the MEM-stage access unit: access-size encodings,
// FSM state encoding and the alignment rule used when MEM_ALIGN_CHECK_EN is defined.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_WORD = 2'b01,
        SZ_HALF = 2'b10,
        SZ_BYTE = 2'b11
    } mem_size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

    localparam int unsigned DATA_W = 32;

    function automatic logic is_misaligned(mem_size_e size, logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_WORD: bad = (lane != 2'b00);
            SZ_HALF: bad = lane[0];
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the MEM-stage access unit (master)
// and the data memory (slave).
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables and replicated store data for the
// outgoing access, and lane selection plus sign extension for returning load data.
module mem_lane_align
    import mem_pkg::*;
(
    input  mem_size_e   size,
    input  logic [1:0]  lane,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    always_comb begin
        be        = 4'b0000;
        wdata     = store_data;
        load_data = load_word;
        half_v    = lane[1] ? load_word[31:16] : load_word[15:0];
        byte_v    = load_word[{lane, 3'b000} +: 8];
        case (size)
            SZ_WORD: begin
                be        = 4'b1111;
                wdata     = store_data;
                load_data = load_word;
            end
            SZ_HALF: begin
                be        = lane[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{half_v[15]}}, half_v};
            end
            SZ_BYTE: begin
                be        = 4'b0001 << lane;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{byte_v[7]}}, byte_v};
            end
            default: begin
                be        = 4'b0000;
                wdata     = store_data;
                load_data = load_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: sequences one data-memory access per instruction and
// registers the MEM/WB results. Define MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no access outstanding; non-memory ops pass straight to WB
// ST_BUSY | dmem request held on the bus until dmem_ready
module mem_access_unit
    import mem_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] ALUResult_MEM,
    input  logic [31:0] rt_Register_Value_MEM,
    input  logic [4:0]  RegDst1Result_MEM,
    input  logic [1:0]  MemRead_MEM,
    input  logic [1:0]  MemWrite_MEM,
    input  logic        MemToReg_MEM,
    input  logic        RegWrite_MEM,
    mem_access_unit_if.master dmem,
    output logic        Stall_MEM,
    output logic [31:0] ReadData_WB,
    output logic [31:0] ALUResult_WB,
    output logic [4:0]  RegDst1Result_WB,
    output logic        MemToReg_WB,
    output logic        RegWrite_WB
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic        Misalign_MEM
`endif
);

    mem_state_e  state;
    logic        is_store;
    logic        mem_op;
    logic        misaligned;
    logic        go_busy;
    mem_size_e   op_size;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;

    // A store wins when both read and write sizes are set.
    assign is_store = (MemWrite_MEM != 2'b00);
    assign mem_op   = is_store || (MemRead_MEM != 2'b00);
    assign op_size  = is_store ? mem_size_e'(MemWrite_MEM) : mem_size_e'(MemRead_MEM);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = mem_op && is_misaligned(op_size, ALUResult_MEM[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign go_busy   = (state == ST_IDLE) && mem_op && !misaligned;
    assign Stall_MEM = go_busy || ((state == ST_BUSY) && !dmem.dmem_ready);

    // EX/MEM is frozen while stalled, so the live inputs still describe the op in BUSY.
    mem_lane_align u_lane_align (
        .size       (op_size),
        .lane       (ALUResult_MEM[1:0]),
        .store_data (rt_Register_Value_MEM),
        .load_word  (dmem.dmem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state            <= ST_IDLE;
            dmem.dmem_req    <= 1'b0;
            dmem.dmem_we     <= 1'b0;
            dmem.dmem_addr   <= 32'h0;
            dmem.dmem_be     <= 4'b0000;
            dmem.dmem_wdata  <= 32'h0;
            ReadData_WB      <= 32'h0;
            ALUResult_WB     <= 32'h0;
            RegDst1Result_WB <= 5'd0;
            MemToReg_WB      <= 1'b0;
            RegWrite_WB      <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            Misalign_MEM     <= 1'b0;
`endif
        end else begin
`ifdef MEM_ALIGN_CHECK_EN
            Misalign_MEM <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (go_busy) begin
                        state           <= ST_BUSY;
                        dmem.dmem_req   <= 1'b1;
                        dmem.dmem_we    <= is_store;
                        dmem.dmem_addr  <= {ALUResult_MEM[31:2], 2'b00};
                        dmem.dmem_be    <= lane_be;
                        dmem.dmem_wdata <= lane_wdata;
                        MemToReg_WB     <= 1'b0;
                        RegWrite_WB     <= 1'b0;
                    end else if (mem_op) begin
                        MemToReg_WB  <= 1'b0;
                        RegWrite_WB  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                        Misalign_MEM <= 1'b1;
`endif
                    end else begin
                        ALUResult_WB     <= ALUResult_MEM;
                        RegDst1Result_WB <= RegDst1Result_MEM;
                        MemToReg_WB      <= MemToReg_MEM;
                        RegWrite_WB      <= RegWrite_MEM;
                    end
                end
                ST_BUSY: begin
                    if (dmem.dmem_ready) begin
                        state            <= ST_IDLE;
                        dmem.dmem_req    <= 1'b0;
                        dmem.dmem_we     <= 1'b0;
                        dmem.dmem_be     <= 4'b0000;
                        ALUResult_WB     <= ALUResult_MEM;
                        RegDst1Result_WB <= RegDst1Result_MEM;
                        MemToReg_WB      <= MemToReg_MEM;
                        RegWrite_WB      <= RegWrite_MEM;
                        if (!is_store) begin
                            ReadData_WB <= lane_load;
                        end
                    end else begin
                        MemToReg_WB <= 1'b0;
                        RegWrite_WB <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: WB results go through a scoreboard queue,
// bus fields are checked by a simple memory responder. Exercises MEM_ALIGN_CHECK_EN when defined.
module tb_mem_access_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] ALUResult_MEM;
    logic [31:0] rt_Register_Value_MEM;
    logic [4:0]  RegDst1Result_MEM;
    logic [1:0]  MemRead_MEM;
    logic [1:0]  MemWrite_MEM;
    logic        MemToReg_MEM;
    logic        RegWrite_MEM;
    logic        Stall_MEM;
    logic [31:0] ReadData_WB;
    logic [31:0] ALUResult_WB;
    logic [4:0]  RegDst1Result_WB;
    logic        MemToReg_WB;
    logic        RegWrite_WB;
`ifdef MEM_ALIGN_CHECK_EN
    logic        Misalign_MEM;
`endif

    mem_access_unit_if dmem ();

    mem_access_unit dut (
        .Clk                   (Clk),
        .Reset                 (Reset),
        .ALUResult_MEM         (ALUResult_MEM),
        .rt_Register_Value_MEM (rt_Register_Value_MEM),
        .RegDst1Result_MEM     (RegDst1Result_MEM),
        .MemRead_MEM           (MemRead_MEM),
        .MemWrite_MEM          (MemWrite_MEM),
        .MemToReg_MEM          (MemToReg_MEM),
        .RegWrite_MEM          (RegWrite_MEM),
        .dmem                  (dmem),
        .Stall_MEM             (Stall_MEM),
        .ReadData_WB           (ReadData_WB),
        .ALUResult_WB          (ALUResult_WB),
        .RegDst1Result_WB      (RegDst1Result_WB),
        .MemToReg_WB           (MemToReg_WB),
        .RegWrite_WB           (RegWrite_WB)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .Misalign_MEM          (Misalign_MEM)
`endif
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        m2r;
        logic        rw;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    wb_exp_t mon_e;

    // Memory responder controls and expected bus contents for the current op
    int          mem_delay;
    logic [31:0] mem_rdata;
    bit          spurious_ready;
    bit          expect_req;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    int          busy_cnt;

    initial begin
        dmem.dmem_ready = 1'b0;
        dmem.dmem_rdata = 32'hDEADBEEF;
        busy_cnt = 0;
        forever begin
            @(posedge Clk);
            #1;
            if (dmem.dmem_req) begin
                check_val("bus_req_expected", {31'b0, expect_req}, 32'd1);
                check_val("bus_addr", dmem.dmem_addr, exp_addr);
                check_val("bus_be", {28'b0, dmem.dmem_be}, {28'b0, exp_be});
                check_val("bus_we", {31'b0, dmem.dmem_we}, {31'b0, exp_we});
                if (exp_we) check_val("bus_wdata", dmem.dmem_wdata, exp_wdata);
                if (busy_cnt == mem_delay) begin
                    dmem.dmem_ready = 1'b1;
                    dmem.dmem_rdata = mem_rdata;
                end else begin
                    dmem.dmem_ready = 1'b0;
                    dmem.dmem_rdata = 32'hDEADBEEF;
                end
                busy_cnt++;
            end else begin
                dmem.dmem_ready = spurious_ready;
                dmem.dmem_rdata = 32'hDEADBEEF;
                busy_cnt = 0;
            end
        end
    end

    // Every non-bubble WB cycle retires exactly one scoreboard entry.
    always @(negedge Clk) begin
        if (Reset && (RegWrite_WB || MemToReg_WB)) begin
            if (sb_q.size() == 0) begin
                check_val("sb_nonempty", 32'(sb_q.size()), 32'd1);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("wb_rd", {27'b0, RegDst1Result_WB}, {27'b0, mon_e.rd});
                check_val("wb_alu", ALUResult_WB, mon_e.alu);
                check_val("wb_m2r", {31'b0, MemToReg_WB}, {31'b0, mon_e.m2r});
                check_val("wb_rw", {31'b0, RegWrite_WB}, {31'b0, mon_e.rw});
                if (mon_e.m2r) check_val("wb_rdata", ReadData_WB, mon_e.rdata);
            end
        end
    end

    task automatic drive_nop();
        ALUResult_MEM         = 32'h0;
        rt_Register_Value_MEM = 32'h0;
        RegDst1Result_MEM     = 5'd0;
        MemRead_MEM           = 2'b00;
        MemWrite_MEM          = 2'b00;
        MemToReg_MEM          = 1'b0;
        RegWrite_MEM          = 1'b0;
        expect_req            = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the edge that retires the op.
    task automatic do_op(input logic [1:0] rd_sz, input logic [1:0] wr_sz,
                         input logic [31:0] addr, input logic [31:0] rt,
                         input logic [4:0] rd, input logic m2r, input logic rw,
                         input int delay, input logic [31:0] rdata, input int exp_stall,
                         input logic [3:0] be, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input bit completes, input string tag);
        int      stall_cnt;
        int      n;
        wb_exp_t e;
        ALUResult_MEM         = addr;
        rt_Register_Value_MEM = rt;
        RegDst1Result_MEM     = rd;
        MemRead_MEM           = rd_sz;
        MemWrite_MEM          = wr_sz;
        MemToReg_MEM          = m2r;
        RegWrite_MEM          = rw;
        mem_delay             = delay;
        mem_rdata             = rdata;
        expect_req            = completes && ((rd_sz != 2'b00) || (wr_sz != 2'b00));
        exp_we                = (wr_sz != 2'b00);
        exp_addr              = {addr[31:2], 2'b00};
        exp_be                = be;
        exp_wdata             = wdata;
        if (completes && (rw || m2r)) begin
            e.rd    = rd;
            e.alu   = addr;
            e.rdata = exp_rdata;
            e.m2r   = m2r;
            e.rw    = rw;
            sb_q.push_back(e);
        end
        #1;
        stall_cnt = 0;
        n = 0;
        while (Stall_MEM && n < 20) begin
            stall_cnt++;
            n++;
            @(posedge Clk);
            #2;
            check_val({tag, "_bubble"}, {30'b0, RegWrite_WB, MemToReg_WB}, 32'd0);
        end
        check_val({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
        @(posedge Clk);
        #2;
        check_val({tag, "_wb_valid"}, {31'b0, RegWrite_WB | MemToReg_WB},
                  {31'b0, completes & (rw | m2r)});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d checks", checks);
        $fatal(1, "timeout");
    end

    initial begin
        drive_nop();
        mem_delay      = 0;
        mem_rdata      = 32'h0;
        spurious_ready = 1'b0;
        exp_we         = 1'b0;
        exp_addr       = 32'h0;
        exp_be         = 4'b0000;
        exp_wdata      = 32'h0;
        Reset          = 1'b0;
        repeat (2) @(posedge Clk);
        #2;
        check_val("rst_alu_wb", ALUResult_WB, 32'h0);
        check_val("rst_rdata_wb", ReadData_WB, 32'h0);
        check_val("rst_rd_wb", {27'b0, RegDst1Result_WB}, 32'd0);
        check_val("rst_ctl_wb", {30'b0, RegWrite_WB, MemToReg_WB}, 32'd0);
        check_val("rst_req", {31'b0, dmem.dmem_req}, 32'd0);
        check_val("rst_stall", {31'b0, Stall_MEM}, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        check_val("rst_misalign", {31'b0, Misalign_MEM}, 32'd0);
`endif
        Reset = 1'b1;
        @(posedge Clk);
        #2;

        //     rd  wr  addr          rt            rd  m2r rw dly rdata         stl be       wdata         exp_rdata     ok
        do_op(2'd0, 2'd0, 32'h0000_1234, 32'h0,        5'd5,  0, 1, 0, 32'h0,         0, 4'b0000, 32'h0,        32'h0,        1, "alu");
        do_op(2'd3, 2'd0, 32'h0000_0103, 32'h0,        5'd3,  1, 1, 0, 32'h8000_0000, 1, 4'b1000, 32'h0,        32'hFFFF_FF80, 1, "lb_neg");
        do_op(2'd0, 2'd2, 32'h0000_0202, 32'h0000_BEEF, 5'd0, 0, 0, 0, 32'h0,         1, 4'b1100, 32'hBEEF_BEEF, 32'h0,       1, "sh_hi");
        do_op(2'd1, 2'd0, 32'h0000_0300, 32'h0,        5'd8,  1, 1, 3, 32'hCAFE_F00D, 4, 4'b1111, 32'h0,        32'hCAFE_F00D, 1, "lw_wait");
        do_op(2'd2, 2'd0, 32'h0000_0402, 32'h0,        5'd10, 1, 1, 0, 32'h8001_7FFF, 1, 4'b1100, 32'h0,        32'hFFFF_8001, 1, "lh_hi");
        do_op(2'd2, 2'd0, 32'h0000_0400, 32'h0,        5'd11, 1, 1, 0, 32'h8001_7FFF, 1, 4'b0011, 32'h0,        32'h0000_7FFF, 1, "lh_lo");
        do_op(2'd3, 2'd0, 32'h0000_0501, 32'h0,        5'd12, 1, 1, 1, 32'h0000_7F00, 2, 4'b0010, 32'h0,        32'h0000_007F, 1, "lb_pos");
        do_op(2'd0, 2'd3, 32'h0000_0601, 32'h1234_5678, 5'd0, 0, 0, 0, 32'h0,         1, 4'b0010, 32'h7878_7878, 32'h0,       1, "sb_l1");
        do_op(2'd0, 2'd1, 32'h0000_0700, 32'hA5A5_0001, 5'd0, 0, 0, 0, 32'h0,         1, 4'b1111, 32'hA5A5_0001, 32'h0,       1, "sw");
        do_op(2'd1, 2'd3, 32'h0000_0803, 32'h0000_00AB, 5'd0, 0, 0, 0, 32'h0,         1, 4'b1000, 32'hABAB_ABAB, 32'h0,       1, "rw_both");

        spurious_ready = 1'b1;
        do_op(2'd0, 2'd0, 32'h0000_ABCD, 32'h0,        5'd13, 0, 1, 0, 32'h0,         0, 4'b0000, 32'h0,        32'h0,        1, "alu_rdy");
        do_op(2'd3, 2'd0, 32'h0000_0000, 32'h0,        5'd14, 1, 1, 2, 32'h0000_00FF, 3, 4'b0001, 32'h0,        32'hFFFF_FFFF, 1, "lb_rdy");
        spurious_ready = 1'b0;

`ifdef MEM_ALIGN_CHECK_EN
        do_op(2'd1, 2'd0, 32'h0000_0101, 32'h0,        5'd15, 1, 1, 0, 32'h1122_3344, 0, 4'b1111, 32'h0,        32'h0,        0, "lw_mis");
        check_val("misalign_set", {31'b0, Misalign_MEM}, 32'd1);
        check_val("misalign_no_rw", {31'b0, RegWrite_WB}, 32'd0);
        do_op(2'd0, 2'd0, 32'h0000_0042, 32'h0,        5'd16, 0, 1, 0, 32'h0,         0, 4'b0000, 32'h0,        32'h0,        1, "alu_post");
        check_val("misalign_clear", {31'b0, Misalign_MEM}, 32'd0);
`else
        do_op(2'd1, 2'd0, 32'h0000_0101, 32'h0,        5'd15, 1, 1, 0, 32'h1122_3344, 1, 4'b1111, 32'h0,        32'h1122_3344, 1, "lw_lowbits");
`endif

        // Reset while an access is outstanding
        do_op(2'd0, 2'd0, 32'h0000_5555, 32'h0,        5'd7,  0, 1, 0, 32'h0,         0, 4'b0000, 32'h0,        32'h0,        1, "alu_pre");
        ALUResult_MEM     = 32'h0000_0900;
        RegDst1Result_MEM = 5'd9;
        MemRead_MEM       = 2'b01;
        MemToReg_MEM      = 1'b1;
        RegWrite_MEM      = 1'b1;
        mem_delay         = 10;
        expect_req        = 1'b1;
        exp_we            = 1'b0;
        exp_addr          = 32'h0000_0900;
        exp_be            = 4'b1111;
        @(posedge Clk);
        #2;
        check_val("abort_req_busy", {31'b0, dmem.dmem_req}, 32'd1);
        #1;
        Reset = 1'b0;
        #1;
        check_val("abort_req", {31'b0, dmem.dmem_req}, 32'd0);
        check_val("abort_addr", dmem.dmem_addr, 32'h0);
        check_val("abort_be", {28'b0, dmem.dmem_be}, 32'd0);
        check_val("abort_alu_wb", ALUResult_WB, 32'h0);
        check_val("abort_rd_wb", {27'b0, RegDst1Result_WB}, 32'd0);
        check_val("abort_rdata_wb", ReadData_WB, 32'h0);
        check_val("abort_ctl_wb", {30'b0, RegWrite_WB, MemToReg_WB}, 32'd0);
        drive_nop();
        #1;
        check_val("abort_stall", {31'b0, Stall_MEM}, 32'd0);
        @(posedge Clk);
        #2;
        Reset = 1'b1;
        do_op(2'd1, 2'd0, 32'h0000_0A04, 32'h0,        5'd14, 1, 1, 1, 32'h0102_0304, 2, 4'b1111, 32'h0,        32'h0102_0304, 1, "lw_after_rst");

        drive_nop();
        repeat (3) @(posedge Clk);
        #2;
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port ALUResult_MEM, input, 32, effective address, or non-memory result.
REQ-004 SHALL have port rt_Register_Value_MEM, input, 32, store data.
REQ-005 SHALL have port RegDst1Result_MEM, input, 5, destination register.
REQ-006 SHALL have port MemRead_MEM, input, 2, load size: 00 none, 01 word, 10 half, 11 byte.
REQ-007 SHALL have port MemWrite_MEM, input, 2, store size, same encoding as MemRead_MEM.
REQ-008 SHALL have port MemToReg_MEM, input, 1, writeback-select control.
REQ-009 SHALL have port RegWrite_MEM, input, 1, register-write control.
REQ-010 SHALL have port dmem_req, output, 1, memory request valid.
REQ-011 SHALL have port dmem_we, output, 1, 1=write, 0=read.
REQ-012 SHALL have port dmem_addr, output, 32, word-aligned address (bits 1:0 = 0).
REQ-013 SHALL have port dmem_be, output, 4, byte enables.
REQ-014 SHALL have port dmem_wdata, output, 32, lane-steered store data.
REQ-015 SHALL have port dmem_rdata, input, 32, read data, valid with dmem_ready.
REQ-016 SHALL have port dmem_ready, input, 1, memory completion strobe.
REQ-017 SHALL have port Stall_MEM, output, 1, upstream hold; the EX/MEM register freezes while it is 1.
REQ-018 SHALL have port ReadData_WB / ALUResult_WB, output, 32 each, registered load data / ALU result.
REQ-019 SHALL have port RegDst1Result_WB, output, 5; MemToReg_WB and RegWrite_WB, output, 1 each; all registered.
REQ-020 SHALL have port Misalign_MEM, output, 1, registered misalignment flag (present only per REQ-033).

Function
REQ-021 SHALL implement FSM IDLE/BUSY: IDLE with a memory op (MemRead_MEM or MemWrite_MEM != 00) -> BUSY next edge; BUSY with dmem_ready -> IDLE.
REQ-022 SHALL drive dmem_req=1 only in BUSY; address, be, wdata and we are latched at IDLE->BUSY and held stable until ready.
REQ-023 SHALL set Stall_MEM = (IDLE and memory op) or (BUSY and not dmem_ready), combinationally.
REQ-024 SHALL pass non-memory instructions to the *_WB outputs in 1 cycle; a memory op completes in 2 cycles minimum, with one extra cycle per BUSY cycle without ready.
REQ-025 SHALL load a bubble (RegWrite_WB=0, MemToReg_WB=0) into the WB registers on every edge where Stall_MEM=1.
REQ-026 SHALL load the op's results at the BUSY->IDLE edge, with ReadData_WB = the selected lane of dmem_rdata.
REQ-027 SHALL sign-extend half and byte loads; little-endian, lane = ALUResult_MEM[1:0].
REQ-028 SHALL drive stores: word be=1111; half be=0011 or 1100 by addr[1]; byte be=0001<<addr[1:0]; data replicated across lanes.
REQ-029 SHALL treat MemRead and MemWrite both nonzero as a store (write wins); the load is ignored.
REQ-030 SHALL ignore dmem_ready in IDLE.

Reset
REQ-031 SHALL, on Reset low, immediately force state IDLE, all *_WB outputs 0, dmem_* outputs 0 and Misalign_MEM 0, including mid-BUSY; the pending access is abandoned.
REQ-032 SHALL leave IDLE on the first rising edge after Reset deasserts.

Configuration
REQ-033 SHALL, with MEM_ALIGN_CHECK_EN defined, skip BUSY for a misaligned half/word access (no dmem_req, bubble to WB, Misalign_MEM=1 for one cycle); without it, there is no Misalign_MEM port and low address bits are ignored.

Structure
REQ-034 SHALL take the size encodings and FSM state constants from shared package mem_pkg.
REQ-035 SHALL place lane steering and sign extension in combinational sub-module mem_lane_align.

Verification
REQ-036 SHALL check: ALU op, RegWrite_MEM=1, RegDst1Result_MEM=5, ALUResult_MEM=0x1234 -> next cycle ALUResult_WB=0x1234, RegWrite_WB=1, Stall_MEM=0.
REQ-037 SHALL check: byte load at addr 0x103, rdata=0x80000000, ready in the first BUSY cycle -> ReadData_WB=0xFFFFFF80 after 2 cycles, Stall_MEM high for 1 cycle.
REQ-038 SHALL check: half store at 0x202, rt=0x0000BEEF -> dmem_be=1100, dmem_wdata=0xBEEFBEEF, dmem_addr=0x200, dmem_we=1.
REQ-039 SHALL check: word load with ready delayed 3 cycles -> dmem_addr/be held stable, Stall_MEM high for 4 cycles, bubbles to WB.
REQ-040 SHALL check: Reset low mid-BUSY -> dmem_req=0 and all *_WB outputs 0 asynchronously; after release the next op proceeds normally.
REQ-041 SHALL check: with MEM_ALIGN_CHECK_EN, word load at 0x101 -> no dmem_req, Misalign_MEM=1 for one cycle, RegWrite_WB=0.
